// File: rtl/green_window_3x3_buffer.sv
// 3x3 green-plane window assembler for the R/B-at-B/R interpolation stage.
// Two line buffers (rows r-1, r-2) plus column shift registers build G11..G33
// around centre (r-1, c-1); out_valid only for centres away from the border.
// Optional macro GWIN_POS_OUT_EN adds full centre coordinates out_row/out_col.
module green_window_3x3_buffer #(
    parameter int unsigned DW         = 10,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned CNT_W      = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [DW-1:0]    in_g,
    output logic             out_valid,
    output logic [DW-1:0]    G11,
    output logic [DW-1:0]    G12,
    output logic [DW-1:0]    G13,
    output logic [DW-1:0]    G21,
    output logic [DW-1:0]    G22,
    output logic [DW-1:0]    G23,
    output logic [DW-1:0]    G31,
    output logic [DW-1:0]    G32,
    output logic [DW-1:0]    G33,
    output logic             out_row_par,
    output logic             out_col_par
`ifdef GWIN_POS_OUT_EN
    ,
    output logic [CNT_W-1:0] out_row,
    output logic [CNT_W-1:0] out_col
`endif
);

    localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CNT_W-1:0] ColLast = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] RowLast = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] One     = CNT_W'(1);
    localparam logic [CNT_W-1:0] Two     = CNT_W'(2);

    logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
    logic [CNT_W-1:0] pos_r, pos_c;
    logic [AW-1:0]    addr;

    logic [DW-1:0] lb0_mem [IMG_WIDTH];
    logic [DW-1:0] lb1_mem [IMG_WIDTH];
    logic [DW-1:0] lb0_rd, lb1_rd;

    logic [DW-1:0] g11_q, g12_q, g13_q;
    logic [DW-1:0] g21_q, g22_q, g23_q;
    logic [DW-1:0] g31_q, g32_q, g33_q;

    logic valid_q, valid_d;
    logic row_par_q, col_par_q;

    // Position of the pixel being accepted; in_sof restarts the raster at (0,0).
    always_comb begin
        pos_r = in_sof ? '0 : row_q;
        pos_c = in_sof ? '0 : col_q;
        addr  = pos_c[AW-1:0];
    end

    // Raster counter advance with line and frame wrap.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (in_valid) begin
            if (pos_c == ColLast) begin
                col_d = '0;
                row_d = (pos_r == RowLast) ? '0 : pos_r + One;
            end else begin
                col_d = pos_c + One;
                row_d = pos_r;
            end
        end
    end

    // Row/column counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // Read-before-write: the old contents at addr feed the window this cycle.
    always_comb begin
        lb0_rd = lb0_mem[addr];
        lb1_rd = lb1_mem[addr];
    end

    // Line buffers shift one row down on every accepted pixel; never reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0_mem[addr] <= lb1_rd;
            lb1_mem[addr] <= in_g;
        end
    end

    // Window columns shift left; new right column is {row r-2, row r-1, row r}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g11_q <= '0; g12_q <= '0; g13_q <= '0;
            g21_q <= '0; g22_q <= '0; g23_q <= '0;
            g31_q <= '0; g32_q <= '0; g33_q <= '0;
        end else if (in_valid) begin
            g11_q <= g12_q; g12_q <= g13_q; g13_q <= lb0_rd;
            g21_q <= g22_q; g22_q <= g23_q; g23_q <= lb1_rd;
            g31_q <= g32_q; g32_q <= g33_q; g33_q <= in_g;
        end
    end

    // Rows 0-1 and columns 0-1 cannot form a full window; this also hides
    // stale line-buffer data after reset or a mid-frame in_sof.
    always_comb begin
        valid_d = in_valid && (pos_r >= Two) && (pos_c >= Two);
    end

    // Registered valid and centre parity; parity of (x-1) is the inverse of x[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            row_par_q <= 1'b0;
            col_par_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (in_valid) begin
                row_par_q <= ~pos_r[0];
                col_par_q <= ~pos_c[0];
            end
        end
    end

`ifdef GWIN_POS_OUT_EN
    logic [CNT_W-1:0] out_row_q, out_col_q;

    // Full centre coordinates, updated with the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (in_valid) begin
            out_row_q <= pos_r - One;
            out_col_q <= pos_c - One;
        end
    end

    assign out_row = out_row_q;
    assign out_col = out_col_q;
`endif

    assign out_valid   = valid_q;
    assign out_row_par = row_par_q;
    assign out_col_par = col_par_q;
    assign G11 = g11_q;
    assign G12 = g12_q;
    assign G13 = g13_q;
    assign G21 = g21_q;
    assign G22 = g22_q;
    assign G23 = g23_q;
    assign G31 = g31_q;
    assign G32 = g32_q;
    assign G33 = g33_q;

endmodule

// File: tb/tb_green_window_3x3_buffer.sv
// Directed bench for green_window_3x3_buffer on an 8x6 frame, in_g = 16*r + c.
// Compile with +define+GWIN_POS_OUT_EN to also check out_row/out_col.
module tb_green_window_3x3_buffer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 10;
    localparam int CW = 12;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_sof;
    logic [DW-1:0] in_g;
    logic          out_valid;
    logic [DW-1:0] G11, G12, G13, G21, G22, G23, G31, G32, G33;
    logic          out_row_par, out_col_par;
`ifdef GWIN_POS_OUT_EN
    logic [CW-1:0] out_row, out_col;
`endif

    int checks = 0;
    int errors = 0;

    green_window_3x3_buffer #(
        .DW(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_g(in_g),
        .out_valid(out_valid),
        .G11(G11), .G12(G12), .G13(G13),
        .G21(G21), .G22(G22), .G23(G23),
        .G31(G31), .G32(G32), .G33(G33),
        .out_row_par(out_row_par), .out_col_par(out_col_par)
`ifdef GWIN_POS_OUT_EN
        , .out_row(out_row), .out_col(out_col)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [92:0] o, input logic [92:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [92:0] obs();
        return {out_valid, out_row_par, out_col_par,
                G11, G12, G13, G21, G22, G23, G31, G32, G33};
    endfunction

    // Expected {valid, row_par, col_par, G11..G33} for the pixel accepted at (r,c).
    function automatic logic [92:0] exp_win(input int r, input int c);
        logic [92:0] e;
        e = 93'(1);
        e = (e << 1) | 93'((r - 1) & 1);
        e = (e << 1) | 93'((c - 1) & 1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                e = (e << DW) | 93'(16 * (r - 2 + i) + (c - 2 + j));
        return e;
    endfunction

    task automatic pix(input int r, input int c, input bit sof);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_g     = DW'(16 * r + c);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Feeds a frame from (0,0) with in_sof, up to and including pixel index last_idx.
    task automatic run_frame(input string name, input bit gaps, input int last_idx);
        int pulses;
        int r, c;
        pulses = 0;
        for (int idx = 0; idx <= last_idx; idx++) begin
            r = idx / W;
            c = idx % W;
            pix(r, c, idx == 0);
            if (out_valid === 1'b1) pulses++;
            if (r >= 2 && c >= 2) begin
                chk($sformatf("%s win(%0d,%0d)", name, r, c), obs(), exp_win(r, c));
`ifdef GWIN_POS_OUT_EN
                chk($sformatf("%s pos(%0d,%0d)", name, r, c), {out_row, out_col},
                    {CW'(r - 1), CW'(c - 1)});
`endif
            end else begin
                chk($sformatf("%s border(%0d,%0d)", name, r, c), out_valid, 1'b0);
            end
            if (r == 2 && c == 2) begin
                chk({name, " first window"}, obs(),
                    {1'b1, 1'b1, 1'b1, 10'd0, 10'd1, 10'd2, 10'd16, 10'd17, 10'd18,
                     10'd32, 10'd33, 10'd34});
`ifdef GWIN_POS_OUT_EN
                chk({name, " first pos"}, {out_row, out_col}, {12'd1, 12'd1});
`endif
            end
            if (gaps && (idx % 2 == 1)) begin
                for (int k = 0; k < 3; k++) begin
                    idle();
                    chk($sformatf("%s gap valid(%0d,%0d)", name, r, c), out_valid, 1'b0);
                    chk($sformatf("%s gap hold(%0d,%0d)", name, r, c), G33, DW'(16 * r + c));
                end
            end
        end
        if (last_idx == W * H - 1) begin
            chk({name, " pulse count"}, 93'(pulses), 93'(24));
            chk({name, " last G33"}, G33, 10'd87);
            chk({name, " last G11"}, G11, 10'd53);
`ifdef GWIN_POS_OUT_EN
            chk({name, " last pos"}, {out_row, out_col}, {12'd4, 12'd6});
`endif
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_g     = '0;
        #1;
        chk("reset state", obs(), 93'(0));
`ifdef GWIN_POS_OUT_EN
        chk("reset pos", {out_row, out_col}, 24'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame("full", 1'b0, W * H - 1);
        idle();
        chk("valid drops after idle", out_valid, 1'b0);
        chk("G33 holds after idle", G33, 10'd87);

        run_frame("gaps", 1'b1, W * H - 1);

        // Frame reaching (3,3), then in_sof arrives where (3,4) would be.
        run_frame("pre-sof", 1'b0, 3 * W + 3);
        run_frame("mid-sof", 1'b0, 2 * W + 5);

        // Reset asserted mid-row 3: outputs clear without a clock edge.
        run_frame("pre-rst", 1'b0, 3 * W + 3);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("async reset outputs", obs(), 93'(0));
`ifdef GWIN_POS_OUT_EN
        chk("async reset pos", {out_row, out_col}, 24'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post-rst", 1'b0, 2 * W + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/green_window_3x3_buffer.md
Name: green_window_3x3_buffer

Overview:
- Upstream companion of the pipelined R/B-at-B/R Hamilton interpolator.
- Takes the raster-order full-green plane from the G-at-R/B stage: raw G at green sites, interpolated G at R/B sites.
- Assembles a 3x3 green neighbourhood, G11..G33, using two line buffers and column shift registers.
- The R/B stage reads G11/G13/G31/G33 as g33/g35/g53/g55; it also gets the centre parity so it can tell R/B sites from G sites.

Parameters:
- DW, 10, pixel bit width
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame
- CNT_W, 12, width of the row and column counters; must satisfy 2^CNT_W > max(IMG_WIDTH, IMG_HEIGHT)

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  qualifies in_g and in_sof; there is no backpressure
- in_sof  in  1  start of frame; sampled only when in_valid=1
- in_g  in  DW  full-plane green sample, raster order
- out_valid  out  1  window outputs are valid this cycle
- G11,G12,G13  out  DW each  top window row (r-2), columns c-2, c-1, c
- G21,G22,G23  out  DW each  middle window row (r-1)
- G31,G32,G33  out  DW each  bottom window row (r), columns c-2, c-1, c
- out_row_par  out  1  row parity of the window centre (r-1)
- out_col_par  out  1  column parity of the window centre (c-1)

Behaviour:
- Reset (async assert, sync release): all outputs, counters and column shift registers go to 0. Line-buffer RAM is not cleared; its contents are never exposed, see the row>=2 gating below.
- Accepted pixel: in_valid=1. Its position (r,c) comes from internal counters. If in_sof=1, the position is forced to (0,0) and counting restarts from it.
- Counter update after each accepted pixel:
  - c increments.
  - At c=IMG_WIDTH-1, c wraps to 0 and r increments.
  - At r=IMG_HEIGHT-1 and c=IMG_WIDTH-1, both wrap to 0.
- Line buffers: lb1 holds row r-1, lb0 holds row r-2, both indexed by c. On each accepted pixel:
  - read lb1[c] and lb0[c];
  - write lb0[c] <= lb1[c];
  - write lb1[c] <= in_g.
  - Read-before-write on the same address; the buffer depth is IMG_WIDTH.
- Column shift: each accepted pixel shifts the window left by one column. The new right column is {lb0[c], lb1[c], in_g} into {G13, G23, G33}.
- out_valid is registered:
  - It is 1 in the cycle after an accepted pixel with r>=2 and c>=2; otherwise 0.
  - The window then centres on (r-1, c-1). out_row_par = (r-1)[0], out_col_par = (c-1)[0].
  - Latency: 1 cycle from the accepting edge to out_valid.
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid windows per frame. Border centres produce no output.
- in_valid=0: nothing advances.
  - out_valid drops after one cycle.
  - G outputs hold their last values.
  - Gaps of any length, including mid-line, do not corrupt the window.
- Mid-frame in_sof: counters restart at (0,0). The stale line data is masked because r<2 suppresses out_valid for two lines.
- Reset mid-frame: output stops immediately. The next frame must start with in_sof=1 or from the post-reset (0,0).
- No arithmetic is done; samples pass through unmodified at width DW.

Optional Feature:
- Macro: GWIN_POS_OUT_EN.
- Defined: adds two output ports, out_row [CNT_W-1:0] and out_col [CNT_W-1:0], carrying the full centre coordinates (r-1, c-1). They are registered alongside out_valid and reset to 0.
- Undefined: those ports and their registers do not exist; only the parity outputs are provided.

Test Plan:
- Setup for all scenarios: IMG_WIDTH=8, IMG_HEIGHT=6, continuous in_valid, in_sof on the first pixel, in_g = 16*r + c.
- Accept (2,2) -> next cycle out_valid=1 with:
  - G11=0, G12=1, G13=2;
  - G21=16, G22=17, G23=18;
  - G31=32, G32=33, G33=34;
  - out_row_par=1, out_col_par=1.
- Full frame -> exactly 24 out_valid pulses. None during rows 0-1 or columns 0-1. The last window has G33=87 (0x57), G11=53.
- Same frame with in_valid deasserted for 3 cycles after every 2nd pixel -> the same 24 windows with identical contents.
- in_sof pulsed at (3,4) -> no out_valid until 2 lines later. The first window after it has G33 equal to that pixel's value at new position (2,2).
- rst_n pulled low mid-row 3 -> out_valid and all G outputs are 0 asynchronously. After release and a new in_sof frame, the first window matches the (2,2) case above.
- With GWIN_POS_OUT_EN: for the (2,2) case, out_row=1 and out_col=1. For the final window, out_row=4 and out_col=6.
